// File: rtl/dmem_subsystem.sv
// -----------------------------------------------------------------------------
// dmem_subsystem
//   Data-side memory subsystem sitting on the core's dmem port. One address
//   decoder fronts a word RAM, a free-running 64-bit cycle counter and an
//   8N1 UART transmitter fed by a small TX FIFO.
//
//   Reads are purely combinational from dmemAddr so the core can capture
//   dmemRdata at the edge that closes its M stage; writes commit on that same
//   edge.
//
// Address map (addr[1:0] ignored, all accesses full-word):
//   0x0000_0000 .. RAM_WORDS*4-1 : RAM
//   0x8000_0000 TXDATA  : write pushes wdata[7:0], reads 0
//   0x8000_0004 STATUS  : {23'b0, count[4:0], overflow, busy, empty, full};
//                         any write clears overflow
//   0x8000_0008 CNTLO   : counter bits [31:0], read/write
//   0x8000_000C CNTHI   : counter bits [63:32], read/write
//   anything else       : reads 0, writes ignored
//
// Ports:
//   clk        in   core clock, all state changes on the rising edge
//   rstN       in   synchronous active-low reset (RAM is not reset)
//   dmemAddr   in   32-bit byte address
//   dmemWdata  in   32-bit write data
//   dmemWen    in   write enable for this cycle
//   dmemRdata  out  32-bit read data, combinational from dmemAddr
//   uartTx     out  serial line, idle high
// -----------------------------------------------------------------------------
module dmem_subsystem #(
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic [31:0] dmemAddr,
    input  logic [31:0] dmemWdata,
    input  logic        dmemWen,
    output logic [31:0] dmemRdata,
    output logic        uartTx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    // Word addresses (byte address >> 2) of the peripheral registers.
    localparam logic [29:0] W_TXDATA = 30'h2000_0000;
    localparam logic [29:0] W_STATUS = 30'h2000_0001;
    localparam logic [29:0] W_CNTLO  = 30'h2000_0002;
    localparam logic [29:0] W_CNTHI  = 30'h2000_0003;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------ decode
    logic [29:0]   word;
    logic          sel_ram, sel_tx, sel_status, sel_cntlo, sel_cnthi;
    logic [AW-1:0] ram_idx;
    logic          wr_ok;
    logic          addr_lsb_unused;

    assign word       = dmemAddr[31:2];
    assign sel_ram    = (dmemAddr[31:AW+2] == '0);
    assign sel_tx     = (word == W_TXDATA);
    assign sel_status = (word == W_STATUS);
    assign sel_cntlo  = (word == W_CNTLO);
    assign sel_cnthi  = (word == W_CNTHI);
    assign ram_idx    = dmemAddr[AW+1:2];
    // Writes presented while reset is asserted never take effect anywhere.
    assign wr_ok      = dmemWen && rstN;
    // Byte-lane bits carry no meaning for full-word accesses.
    assign addr_lsb_unused = ^dmemAddr[1:0];

    // --------------------------------------------------------------------- RAM
    logic [31:0] ram [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_ok && sel_ram) begin
            ram[ram_idx] <= dmemWdata;
        end
    end

    // ----------------------------------------------------------------- counter
    // A load replaces one half and suppresses that cycle's increment, so the
    // other half holds and no carry crosses between halves on a load.
    logic [63:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cnt <= '0;
        end else if (dmemWen && sel_cntlo) begin
            cnt[31:0] <= dmemWdata;
        end else if (dmemWen && sel_cnthi) begin
            cnt[63:32] <= dmemWdata;
        end else begin
            cnt <= cnt + 64'd1;
        end
    end

    // ----------------------------------------------------------------- TX FIFO
    // Handshakes: the push side is valid on a TXDATA write and ready when not
    // full (both judged before the edge); a push that is not ready is dropped
    // and raises sticky overflow. The pop side is valid when not empty and
    // ready when the serializer is IDLE or finishing a stop bit; a transfer
    // happens on the edge where valid and ready are both high.
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic          full, empty, push, pop;
    logic [7:0]    head;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic          tx;
    logic          bit_done, busy;

    assign full     = (count == 5'(FIFO_DEPTH));
    assign empty    = (count == 5'd0);
    assign push     = wr_ok && sel_tx && !full;
    assign head     = fifo_mem[rd_ptr];
    assign bit_done = (timer == TW'(CLKS_PER_BIT - 1));
    assign busy     = (state != S_IDLE);
    assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && bit_done));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= dmemWdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 5'd0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + 5'd1;
            end else if (pop && !push) begin
                count <= count - 5'd1;
            end
            if (dmemWen && sel_tx && full) begin
                overflow <= 1'b1;
            end else if (dmemWen && sel_status) begin
                overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------- serializer
    // tx is registered and updated together with each state change, so the
    // line level always belongs to the state entered on that edge.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shifter <= 8'd0;
            tx      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        shifter <= head;
                        timer   <= '0;
                        tx      <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        timer   <= '0;
                        bit_idx <= 3'd0;
                        tx      <= shifter[0];
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= shifter >> 1;
                            tx      <= shifter[1];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        timer <= '0;
                        // Back-to-back frames: the next start bit follows the
                        // stop bit with no idle gap.
                        if (!empty) begin
                            shifter <= head;
                            tx      <= 1'b0;
                            state   <= S_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign uartTx = tx;

    // -------------------------------------------------------------- read mux
    always_comb begin
        dmemRdata = 32'd0;
        if (sel_ram) begin
            dmemRdata = ram[ram_idx];
        end else if (sel_status) begin
            dmemRdata = {23'd0, count, overflow, busy, empty, full};
        end else if (sel_cntlo) begin
            dmemRdata = cnt[31:0];
        end else if (sel_cnthi) begin
            dmemRdata = cnt[63:32];
        end
    end

endmodule

// File: tb/tb_dmem_subsystem.sv
// -----------------------------------------------------------------------------
// tb_dmem_subsystem
//   Directed + randomized bench for dmem_subsystem (RAM_WORDS=1024,
//   FIFO_DEPTH=8, CLKS_PER_BIT=4). Reference model: RAM as an associative
//   array, the counter as "value loaded at cycle c0 plus elapsed cycles",
//   and the UART as a queue of bytes expected on the line, compared against
//   a line decoder that samples each bit centre.
// -----------------------------------------------------------------------------
module tb_dmem_subsystem;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int WORDS = 1024;
    localparam int FRAME = 10 * CPB;

    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_LO = 32'h8000_0008;
    localparam logic [31:0] A_HI = 32'h8000_000C;

    // ------------------------------------------------------ clock and reset
    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic        dmemWen, uartTx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_subsystem #(
        .RAM_WORDS   (WORDS),
        .FIFO_DEPTH  (DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .dmemAddr (dmemAddr),
        .dmemWdata(dmemWdata),
        .dmemWen  (dmemWen),
        .dmemRdata(dmemRdata),
        .uartTx   (uartTx)
    );

    // ------------------------------------------------------- reference model
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ram_ref [int];
    logic [63:0] cnt_base = 64'd0;
    int          cnt_cyc = 0;

    // Scoreboard: bytes expected on the line vs. bytes decoded from it.
    logic [7:0]  exp_q [$];
    logic [7:0]  rx_q [$];
    logic        stop_q [$];
    int          start_q [$];

    function automatic logic [63:0] cnt_now();
        return cnt_base + 64'(cyc - cnt_cyc);
    endfunction

    // ------------------------------------------------------------ line decoder
    int         mon_t = -1;
    int         mon_start = 0;
    int         mon_bad = 0;
    logic [7:0] mon_byte = 8'd0;

    always @(negedge clk) begin
        if (rstN !== 1'b1) begin
            mon_t = -1;
        end else begin
            if (mon_t < 0) begin
                if (uartTx === 1'b0) begin
                    mon_t = 0;
                    mon_start = cyc;
                end
            end else begin
                mon_t = mon_t + 1;
            end
            if (mon_t == CPB / 2 && uartTx !== 1'b0) begin
                mon_bad++;
                mon_t = -1;
            end
            for (int k = 1; k <= 8; k++) begin
                if (mon_t == k * CPB + CPB / 2) mon_byte[k-1] = uartTx;
            end
            if (mon_t == 9 * CPB + CPB / 2) begin
                rx_q.push_back(mon_byte);
                stop_q.push_back(uartTx);
                start_q.push_back(mon_start);
            end
            if (mon_t == FRAME - 1) mon_t = -1;
        end
    end

    // ------------------------------------------------------------ driver tasks
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] v;
        v = cnt_now();
        dmemAddr  = a;
        dmemWdata = d;
        dmemWen   = 1'b1;
        @(posedge clk);
        #1;
        dmemWen = 1'b0;
        if ((a & 32'hFFFF_FFFC) == A_LO) begin
            cnt_base = {v[63:32], d};
            cnt_cyc  = cyc;
        end else if ((a & 32'hFFFF_FFFC) == A_HI) begin
            cnt_base = {d, v[31:0]};
            cnt_cyc  = cyc;
        end else if (a < 32'(WORDS * 4)) begin
            ram_ref[int'(a >> 2)] = d;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        dmemAddr = a;
        dmemWen  = 1'b0;
        #1;
        check(tag, {32'd0, dmemRdata}, {32'd0, exp});
    endtask

    task automatic cnt_chk(input string tag);
        logic [63:0] v;
        v = cnt_now();
        rd(A_LO, v[31:0], {tag, "_lo"});
        rd(A_HI, v[63:32], {tag, "_hi"});
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        dmemAddr = A_ST;
        dmemWen  = 1'b0;
        #1;
        while (dmemRdata[2:1] !== 2'b01 && k < budget) begin
            step();
            dmemAddr = A_ST;
            #1;
            k++;
        end
        check(tag, {62'd0, dmemRdata[2:1]}, 64'd1);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check({tag, "_byte"}, {56'd0, rx_q[i]}, {56'd0, exp_q[i]});
        end
        for (int i = 0; i < stop_q.size(); i++) begin
            check({tag, "_stop"}, {63'd0, stop_q[i]}, 64'd1);
        end
        check({tag, "_startbit"}, 64'(mon_bad), 64'd0);
        rx_q.delete();
        exp_q.delete();
        stop_q.delete();
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < start_q.size(); i++) begin
            check(tag, 64'(start_q[i] - start_q[i-1]), 64'(FRAME));
        end
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] addr_q [$];
        logic [9:0]  frame;
        logic [7:0]  b;
        logic [31:0] a;
        int          n;

        rstN = 1'b0;
        dmemWen = 1'b0;
        dmemAddr = 32'd0;
        dmemWdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        cnt_base = 64'd0;
        cnt_cyc = cyc;

        // Reset state; first cycle after release reads counter 0.
        rd(A_LO, 32'd0, "rst_cntlo");
        rd(A_HI, 32'd0, "rst_cnthi");
        rd(A_ST, 32'h2, "rst_status");
        check("rst_tx", {63'd0, uartTx}, 64'd1);
        step();
        rd(A_LO, 32'd1, "cnt_first_tick");

        // RAM directed.
        wr(32'h10, 32'hDEAD_BEEF);
        wr(32'h14, 32'h1234_5678);
        rd(32'h10, 32'hDEAD_BEEF, "ram_10");
        rd(32'h14, 32'h1234_5678, "ram_14");
        rd(32'h13, 32'hDEAD_BEEF, "ram_13");
        step();
        wr(32'h0, 32'hCAFE_0001);
        wr(32'hFFC, 32'h0BAD_F00D);
        rd(32'hFFC, 32'h0BAD_F00D, "ram_top");
        rd(32'h1000, 32'd0, "ram_past_end");
        rd(32'h0, 32'hCAFE_0001, "ram_0");
        step();

        // RAM random.
        for (int i = 0; i < 24; i++) begin
            a = {20'd0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
            wr(a, $urandom());
            addr_q.push_back(a);
        end
        for (int i = 0; i < addr_q.size(); i++) begin
            rd(addr_q[i] | 32'($urandom_range(0, 3)), ram_ref[int'(addr_q[i] >> 2)], "ram_rand");
            step();
        end

        // Counter directed: carry from low into high half, and 2^64 wrap.
        wr(A_LO, 32'hFFFF_FFFE);
        wr(A_HI, 32'd0);
        step();
        step();
        rd(A_LO, 32'd0, "cnt_carry_lo");
        rd(A_HI, 32'd1, "cnt_carry_hi");
        step();
        wr(A_HI, 32'hFFFF_FFFF);
        wr(A_LO, 32'hFFFF_FFFF);
        step();
        rd(A_LO, 32'd0, "cnt_wrap_lo");
        rd(A_HI, 32'd0, "cnt_wrap_hi");
        step();

        // Counter random loads against the elapsed-cycle model.
        for (int i = 0; i < 8; i++) begin
            wr(($urandom_range(0, 1) == 1) ? A_HI : A_LO, $urandom());
            repeat ($urandom_range(0, 5)) step();
            cnt_chk("cnt_rand");
            step();
        end

        // UART single frame, cycle-exact.
        wr(A_TX, 32'h0000_01A5);
        exp_q.push_back(8'hA5);
        check("tx_push_cycle", {63'd0, uartTx}, 64'd1);
        rd(A_ST, 32'h10, "st_after_push");
        rd(A_TX, 32'd0, "txdata_reads0");
        frame = {1'b1, 8'hA5, 1'b0};
        for (int t = 0; t < FRAME; t++) begin
            step();
            check("tx_bit", {63'd0, uartTx}, {63'd0, frame[t / CPB]});
        end
        rd(A_ST, 32'h6, "busy_last_stop");
        step();
        rd(A_ST, 32'h2, "busy_fell");
        compare_rx("single");

        // UART random: isolated frames, then a back-to-back burst.
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            wr(A_TX, {24'd0, b});
            exp_q.push_back(b);
            wait_idle(FRAME + 20, "rand_idle");
            repeat ($urandom_range(0, 7)) step();
        end
        start_q.delete();
        n = $urandom_range(2, 6);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            wr(A_TX, {24'd0, b});
            exp_q.push_back(b);
        end
        wait_idle(n * FRAME + 20, "burst_idle");
        check_gaps("burst_gap");
        compare_rx("rand");
        cnt_chk("cnt_after_uart");
        step();

        // FIFO fill, full, overflow and drain.
        start_q.delete();
        wr(A_TX, 32'd0);
        exp_q.push_back(8'd0);
        rd(A_ST, 32'h10, "fifo_first_push");
        wr(A_TX, 32'd1);
        exp_q.push_back(8'd1);
        rd(A_ST, 32'h14, "fifo_first_pop");
        for (int i = 2; i < 9; i++) begin
            wr(A_TX, 32'(i));
            exp_q.push_back(8'(i));
        end
        rd(A_ST, 32'h85, "fifo_full");
        wr(A_TX, 32'd9);
        rd(A_ST, 32'h8D, "fifo_overflow");
        wait_idle(9 * FRAME + 40, "fifo_drain");
        rd(A_ST, 32'hA, "ovf_sticky");
        check("fifo_frames", 64'(start_q.size()), 64'd9);
        check_gaps("fifo_gap");
        compare_rx("fifo");
        wr(A_ST, $urandom());
        rd(A_ST, 32'h2, "ovf_cleared");
        repeat (3) step();
        rd(A_ST, 32'h2, "status_write_no_push");

        // Reset during DATA bit 3, with a second byte queued and a RAM write
        // presented in the reset cycle.
        b = 8'h3C;
        wr(A_TX, {24'd0, b});
        wr(A_TX, 32'h0000_00C3);
        repeat (17) step();
        check("mid_frame_bit3", {63'd0, uartTx}, {63'd0, b[3]});
        rstN = 1'b0;
        dmemAddr = 32'h10;
        dmemWdata = 32'h5A5A_5A5A;
        dmemWen = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        dmemWen = 1'b0;
        cnt_base = 64'd0;
        cnt_cyc = cyc;
        check("rst_mid_tx", {63'd0, uartTx}, 64'd1);
        rd(A_ST, 32'h2, "rst_mid_status");
        rd(A_LO, 32'd0, "rst_mid_cntlo");
        rd(32'h10, ram_ref[4], "rst_mid_ram");
        repeat (2 * FRAME) step();
        check("rst_mid_quiet", {63'd0, uartTx}, 64'd1);
        rd(A_ST, 32'h2, "rst_mid_status_later");
        compare_rx("post_reset");

        // Unmapped addresses.
        wr(32'h4000_0000, 32'h55);
        wr(32'h8000_0010, 32'h55);
        rd(32'h4000_0000, 32'd0, "unmapped_4000");
        rd(32'h8000_0010, 32'd0, "unmapped_8010");
        rd(32'h0, ram_ref[0], "unmapped_ram0");
        step();
        rd(32'h10, ram_ref[4], "unmapped_ram10");
        rd(A_ST, 32'h2, "unmapped_status");
        step();
        cnt_chk("unmapped_cnt");
        repeat (FRAME) step();
        compare_rx("unmapped");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_subsystem.md
# dmem_subsystem

Data-side memory subsystem on the core's dmem port, downstream of the memory stage: word RAM, a 64-bit cycle counter and a FIFO-buffered 8N1 UART transmitter behind one address decoder. Reads are combinational from the address so the core can capture `dmemRdata` at the clock edge that ends the M stage. Writes commit on the same edge.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words (power of two).
- `FIFO_DEPTH`, 8: UART TX FIFO entries (power of two, 2..16).
- `CLKS_PER_BIT`, 868: clocks per UART bit (≥2).
- `clk`  in  1  core clock; all state updates on rising edge.
- `rstN`  in  1  reset; one clock; reset is synchronous and active-low.
- `dmemAddr`  in  32  byte address from the core's M stage.
- `dmemWdata`  in  32  write data.
- `dmemWen`  in  1  write enable for this cycle.
- `dmemRdata`  out  32  read data, combinational from `dmemAddr`.
- `uartTx`  out  1  serial output, idle high.

## Operation
- Decode: `addr[1:0]` ignored. All accesses are full-word.
  - `0x0000_0000..RAM_WORDS*4-1`: RAM, index `addr[log2(RAM_WORDS)+1:2]`.
  - `0x8000_0000` TXDATA: write pushes `wdata[7:0]`. Read returns 0.
  - `0x8000_0004` STATUS (read): bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow (sticky), bits[8:4] FIFO count, rest 0.
    - Any write clears overflow.
  - `0x8000_0008` CNTLO / `0x8000_000C` CNTHI: counter halves, read/write.
  - Any other address: reads 0, writes ignored.
- Reads have no side effects.
- RAM: asynchronous read. Write on the edge when `dmemWen` is high. Not reset.
- Counter: 64-bit, increments by 1 every cycle and wraps at 2^64.
  - A write to CNTLO or CNTHI loads that half with `wdata`. The other half keeps its current value.
  - There is no increment in the load cycle, and no carry from the loaded half.
- FIFO: push on a TXDATA write when `full` is false, with `full` evaluated before the edge.
  - A push while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
- Serializer FSM (bit timer counts `CLKS_PER_BIT` cycles per state/bit):
  - IDLE: `uartTx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `uartTx`=0 for one bit time, then DATA.
  - DATA: 8 bits, LSB first, one bit time each, then STOP.
  - STOP: `uartTx`=1 for one bit time. Then go to START (popping) if the FIFO is non-empty, else IDLE. There is no gap between frames.
- Reset (rstN low at an edge), including mid-frame:
  - FSM goes to IDLE; `uartTx`=1 after that edge.
  - FIFO is emptied (count 0); overflow is cleared; counter is 0; bit timer is 0.
  - RAM is untouched.
  - `dmemRdata` reflects the reset state combinationally.
  - Writes in a reset cycle are ignored.

## Timing
- Read latency 0: `dmemRdata` is valid in the same cycle as `dmemAddr`.
- Write visible to a read from the next cycle.
- Push at edge N: STATUS count/empty updated from cycle N.
  - If the FSM was idle with an empty FIFO: pop at edge N+1, start bit begins after edge N+1.
- Frame = 10·`CLKS_PER_BIT` cycles. A back-to-back frame's start bit immediately follows the stop bit.
- busy is deasserted from the cycle after the last stop-bit cycle when the FIFO is empty.
- Counter reads value k in cycle k after reset release (first cycle after release reads 0).

## Test plan
- RAM: write 0xDEADBEEF to 0x10, then 0x12345678 to 0x14. Read 0x10 → 0xDEADBEEF, 0x14 → 0x12345678, 0x13 → 0xDEADBEEF.
- UART (`CLKS_PER_BIT`=4): write 0xA5 to TXDATA. `uartTx` is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1. busy falls 40 cycles after the start bit begins.
- FIFO (`FIFO_DEPTH`=8, `CLKS_PER_BIT`=4): 10 back-to-back writes 0x00..0x09. Observe:
  - first pop, then 8 stored;
  - full seen, 10th write dropped, overflow=1;
  - exactly 9 contiguous frames 0x00..0x08;
  - any write to STATUS → overflow=0.
- Counter: write CNTLO=0xFFFFFFFE, CNTHI=0. Two cycles later read CNTLO=0 and CNTHI=1.
- Reset mid-frame: assert rstN low during DATA bit 3 for one edge. `uartTx`=1 next cycle, STATUS=0x2, CNTLO=0, RAM contents unchanged.
- Unmapped: write 0x55 to 0x4000_0000 and 0x8000_0010 → both read 0. RAM, FIFO and counter are unaffected.
